// File: rtl/figure_pkg.sv
// Shared constants and types for the figure selection controller.
package figure_pkg;

  localparam int N_FIGS = 4;

  localparam logic [1:0] FIG_TRI = 2'd0;
  localparam logic [1:0] FIG_SQR = 2'd1;
  localparam logic [1:0] FIG_CIR = 2'd2;
  localparam logic [1:0] FIG_PEN = 2'd3;

  typedef enum logic [1:0] {
    ST_GRID = 2'd0,
    ST_FULL = 2'd1,
    ST_AUTO = 2'd2
  } view_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_BACK = 2'd2
  } step_e;

  // Modular step of a figure index over n figures.
  function automatic logic [1:0] step_idx(input logic [1:0] idx, input step_e step, input int n);
    logic [1:0] last;
    last = 2'(n - 1);
    step_idx = idx;
    if (step == STEP_FWD) begin
      step_idx = (idx == last) ? 2'd0 : idx + 2'd1;
    end else if (step == STEP_BACK) begin
      step_idx = (idx == 2'd0) ? last : idx - 2'd1;
    end
  endfunction

endpackage

// File: rtl/frame_dwell_counter.sv
// Counts frame ticks and flags the tick on which the dwell period elapses.
module frame_dwell_counter #(
  parameter int DWELL_FRAMES = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic frame_tick,
  output logic expire
);

  localparam logic [7:0] LAST_COUNT = 8'(DWELL_FRAMES - 1);

  logic [7:0] count_q, count_d;

  assign expire = frame_tick && !clear && (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (frame_tick) begin
      count_d = expire ? 8'd0 : count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/figure_select_ctrl.sv
// Chooses which figure is shown and whether it fills the screen; button
// requests are collected during a frame and applied at the next frame tick.
module figure_select_ctrl #(
  parameter int DWELL_FRAMES = 120,
  parameter int N_FIGS       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_full,
  input  logic              auto_en,
  output logic [N_FIGS-1:0] fig_select,
  output logic              full_screen,
  output logic [1:0]        fig_idx,
  output logic              view_update
);

  import figure_pkg::*;

  view_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  step_e       pend_step_q, pend_step_d;
  logic        pend_full_q, pend_full_d;
  logic        view_update_q, view_update_d;
  step_e       btn_step;
  logic        dwell_clear;
  logic        dwell_expire;

  // The counter only runs while in AUTO; a manual step restarts the dwell.
  assign dwell_clear = (state_q != ST_AUTO) || (frame_tick && (pend_step_q != STEP_NONE));

  frame_dwell_counter #(
    .DWELL_FRAMES(DWELL_FRAMES)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (dwell_clear),
    .frame_tick(frame_tick),
    .expire    (dwell_expire)
  );

  always_comb begin
    btn_step = STEP_NONE;
    if (btn_next && !btn_prev) begin
      btn_step = STEP_FWD;
    end else if (btn_prev && !btn_next) begin
      btn_step = STEP_BACK;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pend_step_d   = pend_step_q;
    pend_full_d   = pend_full_q;
    view_update_d = 1'b0;

    if (frame_tick) begin
      pend_step_d = STEP_NONE;
      pend_full_d = 1'b0;

      if (pend_step_q != STEP_NONE) begin
        idx_d = step_idx(idx_q, pend_step_q, N_FIGS);
      end else if (dwell_expire) begin
        idx_d = step_idx(idx_q, STEP_FWD, N_FIGS);
      end

      case (state_q)
        ST_GRID: begin
          if (pend_full_q) state_d = auto_en ? ST_AUTO : ST_FULL;
        end
        ST_FULL: begin
          if (pend_full_q)  state_d = ST_GRID;
          else if (auto_en) state_d = ST_AUTO;
        end
        ST_AUTO: begin
          if (pend_full_q)   state_d = ST_GRID;
          else if (!auto_en) state_d = ST_FULL;
        end
        default: state_d = ST_GRID;
      endcase

      view_update_d = (idx_d != idx_q) || ((state_d == ST_GRID) != (state_q == ST_GRID));
    end

    // Pulses arriving on the tick cycle itself belong to the next frame.
    if (btn_step != STEP_NONE) pend_step_d = btn_step;
    if (btn_full) pend_full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_GRID;
      idx_q         <= 2'd0;
      pend_step_q   <= STEP_NONE;
      pend_full_q   <= 1'b0;
      view_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pend_step_q   <= pend_step_d;
      pend_full_q   <= pend_full_d;
      view_update_q <= view_update_d;
    end
  end

  assign fig_select  = {{(N_FIGS-1){1'b0}}, 1'b1} << idx_q;
  assign full_screen = (state_q != ST_GRID);
  assign fig_idx     = idx_q;
  assign view_update = view_update_q;

endmodule

// File: tb/tb_figure_select_ctrl.sv
// Self-checking bench: directed vector table, randomized run against a
// behavioural model, and a mid-frame reset sequence.
module tb_figure_select_ctrl;

  import figure_pkg::*;

  localparam int DWELL = 3;
  localparam int NF    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_tick, btn_next, btn_prev, btn_full, auto_en;
  logic [NF-1:0] fig_select;
  logic          full_screen;
  logic [1:0]    fig_idx;
  logic          view_update;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0=grid 1=full 2=auto, step -1/0/+1
  int mMode, mIdx, mDwell, mStep;
  bit mFull, mVu;

  typedef struct {
    bit n, p, f, t, a;
    int expIdx;
    bit expFs;
    bit expVu;
  } vec_t;

  vec_t vecs[$];

  figure_select_ctrl #(
    .DWELL_FRAMES(DWELL),
    .N_FIGS      (NF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .btn_full   (btn_full),
    .auto_en    (auto_en),
    .fig_select (fig_select),
    .full_screen(full_screen),
    .fig_idx    (fig_idx),
    .view_update(view_update)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mIdx = 0; mDwell = 0; mStep = 0; mFull = 0; mVu = 0;
  endtask

  task automatic modelUpdate(input bit n, input bit p, input bit f, input bit t, input bit a);
    int newIdx, newMode;
    mVu = 0;
    if (t) begin
      newIdx  = mIdx;
      newMode = mMode;
      if (mStep != 0) newIdx = (mIdx + mStep + NF) % NF;
      else if (mMode == 2 && mDwell == DWELL - 1) newIdx = (mIdx + 1) % NF;
      if (mMode == 2) begin
        if (mStep != 0 || mDwell == DWELL - 1) mDwell = 0;
        else mDwell++;
      end
      if (mFull) newMode = (mMode == 0) ? (a ? 2 : 1) : 0;
      else if (mMode == 1 && a) newMode = 2;
      else if (mMode == 2 && !a) newMode = 1;
      if (newMode != 2) mDwell = 0;
      mVu   = (newIdx != mIdx) || ((newMode != 0) != (mMode != 0));
      mIdx  = newIdx;
      mMode = newMode;
      mStep = 0;
      mFull = 0;
    end
    if (n && !p) mStep = 1;
    else if (p && !n) mStep = -1;
    if (f) mFull = 1;
  endtask

  task automatic applyStimulus(input bit n, input bit p, input bit f, input bit t, input bit a);
    btn_next = n; btn_prev = p; btn_full = f; frame_tick = t; auto_en = a;
    @(posedge clk);
    #1;
    modelUpdate(n, p, f, t, a);
    btn_next = 0; btn_prev = 0; btn_full = 0; frame_tick = 0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_idx"}, int'(fig_idx), mIdx);
    checkOutput({tag, "_sel"}, int'(fig_select), 1 << mIdx);
    checkOutput({tag, "_full"}, int'(full_screen), int'(mMode != 0));
    checkOutput({tag, "_vu"}, int'(view_update), int'(mVu));
  endtask

  task automatic doReset();
    rst_n = 0; frame_tick = 0; btn_next = 0; btn_prev = 0; btn_full = 0; auto_en = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_sel", int'(fig_select), 1);
    checkOutput("reset_full", int'(full_screen), 0);
    checkOutput("reset_vu", int'(view_update), 0);
    @(negedge clk);
    rst_n = 1;
    modelReset();
  endtask

  task automatic addVec(input bit n, input bit p, input bit f, input bit t, input bit a,
                        input int idx, input bit fs, input bit vu);
    vec_t v;
    v.n = n; v.p = p; v.f = f; v.t = t; v.a = a;
    v.expIdx = idx; v.expFs = fs; v.expVu = vu;
    vecs.push_back(v);
  endtask

  initial begin
    bit n, p, f, t, a;

    //     n p f t a   idx      fs vu
    addVec(0,0,1,0,0, FIG_TRI, 0, 0);
    addVec(0,0,0,1,0, FIG_TRI, 1, 1);
    addVec(0,0,0,0,0, FIG_TRI, 1, 0);
    addVec(0,1,0,0,0, FIG_TRI, 1, 0);
    addVec(0,0,0,1,0, FIG_PEN, 1, 1);
    addVec(1,0,0,0,0, FIG_PEN, 1, 0);
    addVec(0,0,0,1,0, FIG_TRI, 1, 1);
    addVec(1,1,0,0,0, FIG_TRI, 1, 0);
    addVec(0,0,0,1,0, FIG_TRI, 1, 0);
    addVec(1,0,0,1,0, FIG_TRI, 1, 0);
    addVec(0,0,0,1,0, FIG_SQR, 1, 1);
    addVec(1,0,0,0,0, FIG_SQR, 1, 0);
    addVec(0,0,0,1,0, FIG_CIR, 1, 1);
    addVec(0,0,0,1,1, FIG_CIR, 1, 0);
    addVec(0,0,0,1,1, FIG_CIR, 1, 0);
    addVec(0,0,0,1,1, FIG_CIR, 1, 0);
    addVec(0,0,0,1,1, FIG_PEN, 1, 1);
    addVec(0,0,0,0,1, FIG_PEN, 1, 0);
    addVec(0,0,0,1,1, FIG_PEN, 1, 0);
    addVec(0,0,0,1,1, FIG_PEN, 1, 0);
    addVec(0,0,0,1,1, FIG_TRI, 1, 1);
    addVec(0,0,0,1,0, FIG_TRI, 1, 0);
    addVec(0,0,1,0,0, FIG_TRI, 1, 0);
    addVec(0,0,0,1,0, FIG_TRI, 0, 1);

    doReset();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].n, vecs[i].p, vecs[i].f, vecs[i].t, vecs[i].a);
      checkOutput($sformatf("vec%0d_idx", i), int'(fig_idx), vecs[i].expIdx);
      checkOutput($sformatf("vec%0d_sel", i), int'(fig_select), 1 << vecs[i].expIdx);
      checkOutput($sformatf("vec%0d_full", i), int'(full_screen), int'(vecs[i].expFs));
      checkOutput($sformatf("vec%0d_vu", i), int'(view_update), int'(vecs[i].expVu));
    end

    doReset();
    a = 0;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(3) == 0);
      n = ($urandom_range(7) == 0);
      p = ($urandom_range(7) == 0);
      f = ($urandom_range(11) == 0);
      if ($urandom_range(39) == 0) a = !a;
      applyStimulus(n, p, f, t, a);
      checkModel($sformatf("rand%0d", i));
    end

    // Reach a non-reset view, leave a full-screen request pending, then reset mid-frame.
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkModel("prereset");
    applyStimulus(0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    checkOutput("midreset_sel", int'(fig_select), 1);
    checkOutput("midreset_full", int'(full_screen), 0);
    checkOutput("midreset_vu", int'(view_update), 0);
    @(negedge clk);
    rst_n = 1;
    modelReset();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("postreset_full", int'(full_screen), 0);
    checkOutput("postreset_sel", int'(fig_select), 1);
    checkOutput("postreset_vu", int'(view_update), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/figure_select_ctrl.md
FIGURE_SELECT_CTRL -- requirements
Module: figure_select_ctrl

Interface
REQ-001 SHALL provide parameter DWELL_FRAMES, default 120, frames each figure is held in auto mode (legal 1..255).
REQ-002 SHALL provide parameter N_FIGS, default 4, number of figure objects (fixed order: triangle, square, circle, pentagon).
REQ-003 SHALL have port clk  input  1  system pixel clock; sole clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-006 SHALL have port btn_next  input  1  one-cycle pulse (pre-debounced): advance figure.
REQ-007 SHALL have port btn_prev  input  1  one-cycle pulse: step figure back.
REQ-008 SHALL have port btn_full  input  1  one-cycle pulse: toggle grid/full-screen view.
REQ-009 SHALL have port auto_en  input  1  level: enable auto-cycling.
REQ-010 SHALL have port fig_select  output  N_FIGS  one-hot select to figure objects' *_select inputs.
REQ-011 SHALL have port full_screen  output  1  drives every figure object's full_screen input.
REQ-012 SHALL have port fig_idx  output  2  binary index of selected figure.
REQ-013 SHALL have port view_update  output  1  one-cycle pulse when outputs changed at a frame_tick.

Function
REQ-014 SHALL keep FSM states GRID (full_screen=0), FULL (full_screen=1, manual), AUTO (full_screen=1, timed).
REQ-015 SHALL latch button pulses into pending registers (pend_step: -1/0/+1, pend_full) on any cycle; outputs SHALL change only on the cycle after frame_tick (one-cycle latency, registered).
REQ-016 SHALL, for btn_next and btn_prev in the same cycle, discard both; a later pulse SHALL overwrite an earlier pending step (last wins, no accumulation).
REQ-017 SHALL, at frame_tick with pend_step=+1, set idx=(idx+1) mod N_FIGS; with -1, idx=(idx-1) mod N_FIGS (0 wraps to N_FIGS-1).
REQ-018 SHALL transition GRID->FULL on pend_full, or GRID->AUTO if auto_en=1; FULL/AUTO->GRID on pend_full.
REQ-019 SHALL transition FULL->AUTO when auto_en=1 and AUTO->FULL when auto_en=0, evaluated at frame_tick.
REQ-020 SHALL, in AUTO, count frame_ticks in an 8-bit dwell counter; on reaching DWELL_FRAMES-1 it SHALL advance idx by +1 and clear the counter on the same tick.
REQ-021 SHALL clear the dwell counter on entering AUTO and on any manual step applied in AUTO.
REQ-022 SHALL apply step and view-toggle pending in the same frame together (idx changes and state changes at one tick).
REQ-023 SHALL clear all pending registers at each frame_tick after applying them; a button pulse coincident with frame_tick SHALL be held for the next frame.
REQ-024 SHALL assert view_update for exactly one cycle after a frame_tick that changed fig_select or full_screen; no pulse otherwise.
REQ-025 SHALL drive fig_select = 1<<idx in every state (objects ignore it in grid view).

Reset
REQ-026 SHALL, while rst_n=0, force state=GRID, idx=0, fig_select=0001, full_screen=0, view_update=0, dwell counter=0, pending cleared.
REQ-027 SHALL, on reset asserted mid-frame with pending requests, discard those requests.

Structure
REQ-028 SHALL place figure index constants (FIG_TRI=0, FIG_SQR=1, FIG_CIR=2, FIG_PEN=3), N_FIGS and the state encoding in shared package figure_pkg.
REQ-029 SHALL implement the dwell counter as sub-module frame_dwell_counter (inputs clk, rst_n, clear, frame_tick; output expire).

Verification
REQ-030 Reset, then btn_full, then frame_tick -> next cycle full_screen=1, fig_select=0001, view_update=1 for one cycle.
REQ-031 In FULL idx=0: btn_prev, frame_tick -> fig_select=1000, fig_idx=3; btn_next then frame_tick -> 0001.
REQ-032 btn_next and btn_prev same cycle, frame_tick -> no change, view_update stays 0.
REQ-033 DWELL_FRAMES=3, auto_en=1, FULL idx=2: enter AUTO; after 3 frame_ticks -> idx=3, after 3 more -> idx=0.
REQ-034 btn_next coincident with frame_tick -> no change this frame; applied at the following frame_tick.
REQ-035 rst_n low mid-frame with btn_full pending -> outputs at reset values; next frame_tick yields no change.
